// File: rtl/mini_src_pkg.sv
// Shared definitions for the instruction-register / select-encode slice:
// IR field positions, register-file width and a constant sign-extend helper.
package mini_src_pkg;

  localparam int unsigned IR_W    = 32;
  localparam int unsigned OP_MSB  = 31;
  localparam int unsigned OP_LSB  = 27;
  localparam int unsigned OP_W    = OP_MSB - OP_LSB + 1;
  localparam int unsigned RA_LSB  = 23;
  localparam int unsigned RB_LSB  = 19;
  localparam int unsigned RC_LSB  = 15;
  localparam int unsigned C_MSB   = 18;
  localparam int unsigned FIELD_W = 4;
  localparam int unsigned NUM_GR  = 16;

  typedef logic [FIELD_W-1:0] gr_idx_t;
  typedef logic [NUM_GR-1:0]  gr_vec_t;

  // Sign-extend the 19-bit C constant to the full bus width.
  function automatic logic [IR_W-1:0] sext_c(input logic [IR_W-1:0] ir);
    return {{(IR_W-C_MSB-1){ir[C_MSB]}}, ir[C_MSB:0]};
  endfunction

endpackage

// File: rtl/ir_select_encode_if.sv
// Control/bus bundle between the control unit, the bus and ir_select_encode.
// master: the driving side (control + bus); slave: ir_select_encode.
interface ir_select_encode_if
  import mini_src_pkg::*;
#(
  parameter int unsigned ERR_CW = 8
);
  logic [IR_W-1:0]   BusMuxOut;
  logic              IRin;
  logic              Gra;
  logic              Grb;
  logic              Grc;
  logic              Rin;
  logic              Rout;
  logic              BAout;
  logic [NUM_GR-1:0] GRin;
  logic [NUM_GR-1:0] GRoutA;
  logic              BAout_q;
  logic [IR_W-1:0]   C_sext;
  logic [OP_W-1:0]   opcode;
  logic [IR_W-1:0]   ir_q;
  logic              sel_err;
  logic [ERR_CW-1:0] err_cnt;

  modport master (
    output BusMuxOut, IRin, Gra, Grb, Grc, Rin, Rout, BAout,
    input  GRin, GRoutA, BAout_q, C_sext, opcode, ir_q, sel_err, err_cnt
  );

  modport slave (
    input  BusMuxOut, IRin, Gra, Grb, Grc, Rin, Rout, BAout,
    output GRin, GRoutA, BAout_q, C_sext, opcode, ir_q, sel_err, err_cnt
  );
endinterface

// File: rtl/onehot_dec4to16.sv
// 4-to-16 one-hot decoder with enable; all-zero output when disabled.
module onehot_dec4to16
  import mini_src_pkg::*;
(
  input  gr_idx_t sel,
  input  logic    en,
  output gr_vec_t onehot
);

  // Single set bit at position sel while enabled.
  always_comb begin
    onehot = '0;
    if (en) onehot[sel] = 1'b1;
  end

endmodule

// File: rtl/ir_select_encode.sv
// Instruction register plus Ra/Rb/Rc field select and one-hot register-file
// strobe generation. Optional select-conflict monitor built when the
// SEL_CHECK_EN macro is defined; otherwise sel_err/err_cnt are tied low.
module ir_select_encode
  import mini_src_pkg::*;
#(
  parameter logic [IR_W-1:0] IR_RST = 32'h0,
  parameter int unsigned     ERR_CW = 8
) (
  input  logic              clk,
  input  logic              reg_clear_n,
  ir_select_encode_if.slave bus
);

  logic [IR_W-1:0] ir;
  gr_idx_t         sel;
  logic            rd_en;
  logic            conflict;

  // IR register: reset wins over a load.
  always_ff @(posedge clk) begin
    if (!reg_clear_n)  ir <= IR_RST;
    else if (bus.IRin) ir <= bus.BusMuxOut;
  end

  // Field select from the registered IR (a same-cycle load is not seen).
  always_comb begin
    sel = '0;
    if (bus.Gra) sel = sel | ir[RA_LSB +: FIELD_W];
    if (bus.Grb) sel = sel | ir[RB_LSB +: FIELD_W];
    if (bus.Grc) sel = sel | ir[RC_LSB +: FIELD_W];
  end

  // Read side is enabled by either read strobe form.
  always_comb begin
    rd_en    = bus.Rout | bus.BAout;
    conflict = ((bus.Gra & bus.Grb) | (bus.Gra & bus.Grc) | (bus.Grb & bus.Grc))
             & (bus.Rin | rd_en);
  end

  onehot_dec4to16 u_dec_in (
    .sel    (sel),
    .en     (bus.Rin),
    .onehot (bus.GRin)
  );

  onehot_dec4to16 u_dec_out (
    .sel    (sel),
    .en     (rd_en),
    .onehot (bus.GRoutA)
  );

  // IR-derived outputs and base-address qualifier pass-through.
  always_comb begin
    bus.ir_q    = ir;
    bus.opcode  = ir[OP_MSB:OP_LSB];
    bus.C_sext  = sext_c(ir);
    bus.BAout_q = bus.BAout;
  end

`ifdef SEL_CHECK_EN
  logic              sel_err_r;
  logic [ERR_CW-1:0] err_cnt_r;

  // Sticky conflict flag and saturating conflict-cycle counter.
  always_ff @(posedge clk) begin
    if (!reg_clear_n) begin
      sel_err_r <= 1'b0;
      err_cnt_r <= '0;
    end else if (conflict) begin
      sel_err_r <= 1'b1;
      if (err_cnt_r != '1) err_cnt_r <= err_cnt_r + 1'b1;
    end
  end

  // Drive the monitor state onto the bundle.
  always_comb begin
    bus.sel_err = sel_err_r;
    bus.err_cnt = err_cnt_r;
  end
`else
  logic unused_conflict;

  // Monitor absent: outputs tied low.
  always_comb begin
    unused_conflict = conflict;
    bus.sel_err     = 1'b0;
    bus.err_cnt     = '0;
  end
`endif

endmodule

// File: tb/tb_ir_select_encode.sv
// Scoreboard bench for ir_select_encode: a driver issues one stimulus per
// cycle and queues the expected outputs from a field-level reference model;
// a monitor on the falling edge pops and compares.
module tb_ir_select_encode;

  localparam int unsigned ERR_CW  = 8;
  localparam int          CNT_MAX = (1 << ERR_CW) - 1;

  typedef struct {
    logic        rst_n;
    logic [31:0] bus;
    logic        irin, gra, grb, grc, rin, rout, baout;
  } stim_t;

  typedef struct {
    logic [15:0] grin;
    logic [15:0] grout;
    logic        baq;
    logic [31:0] csext;
    logic [4:0]  op;
    logic [31:0] ir;
    logic        err;
    logic [7:0]  cnt;
  } exp_t;

  logic clk = 1'b0;
  logic reg_clear_n;

  ir_select_encode_if #(.ERR_CW(ERR_CW)) ifc ();

  ir_select_encode #(.IR_RST(32'h0), .ERR_CW(ERR_CW)) dut (
    .clk         (clk),
    .reg_clear_n (reg_clear_n),
    .bus         (ifc)
  );

  always #5 clk = ~clk;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  // Reference model state
  logic [31:0] m_ir  = 32'h0;
  logic        m_err = 1'b0;
  int          m_cnt = 0;

  function automatic exp_t predict(input stim_t s);
    exp_t e;
    int   ra, rb, rc, sel, c;
    ra  = int'(m_ir[26:23]);
    rb  = int'(m_ir[22:19]);
    rc  = int'(m_ir[18:15]);
    sel = (s.gra ? ra : 0) | (s.grb ? rb : 0) | (s.grc ? rc : 0);
    e.grin  = s.rin ? 16'(2 ** sel) : 16'h0;
    e.grout = (s.rout || s.baout) ? 16'(2 ** sel) : 16'h0;
    e.baq   = s.baout;
    c = int'(m_ir[18:0]);
    if (c >= (1 << 18)) c = c - (1 << 19);
    e.csext = 32'(c);
    e.op    = m_ir[31:27];
    e.ir    = m_ir;
`ifdef SEL_CHECK_EN
    e.err = m_err;
    e.cnt = 8'(m_cnt);
`else
    e.err = 1'b0;
    e.cnt = 8'h0;
`endif
    return e;
  endfunction

  function automatic void advance(input stim_t s);
    int ngr;
    if (!s.rst_n) begin
      m_ir  = 32'h0;
      m_err = 1'b0;
      m_cnt = 0;
    end else begin
      if (s.irin) m_ir = s.bus;
      ngr = int'(s.gra) + int'(s.grb) + int'(s.grc);
      if (ngr >= 2 && (s.rin || s.rout || s.baout)) begin
        m_err = 1'b1;
        if (m_cnt < CNT_MAX) m_cnt = m_cnt + 1;
      end
    end
  endfunction

  task automatic do_cycle(input stim_t s);
    reg_clear_n   = s.rst_n;
    ifc.BusMuxOut = s.bus;
    ifc.IRin      = s.irin;
    ifc.Gra       = s.gra;
    ifc.Grb       = s.grb;
    ifc.Grc       = s.grc;
    ifc.Rin       = s.rin;
    ifc.Rout      = s.rout;
    ifc.BAout     = s.baout;
    exp_q.push_back(predict(s));
    advance(s);
    @(posedge clk);
    #1;
  endtask

  function automatic stim_t mk(input logic rst_n, input logic [31:0] bus, input logic irin,
                               input logic gra, input logic grb, input logic grc,
                               input logic rin, input logic rout, input logic baout);
    stim_t s;
    s.rst_n = rst_n; s.bus = bus; s.irin = irin;
    s.gra = gra; s.grb = grb; s.grc = grc;
    s.rin = rin; s.rout = rout; s.baout = baout;
    return s;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
  endtask

  // Monitor: outputs are presented every cycle; compare at the falling edge.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk("GRin",    32'(ifc.GRin),    32'(e.grin));
      chk("GRoutA",  32'(ifc.GRoutA),  32'(e.grout));
      chk("BAout_q", 32'(ifc.BAout_q), 32'(e.baq));
      chk("C_sext",  ifc.C_sext,       e.csext);
      chk("opcode",  32'(ifc.opcode),  32'(e.op));
      chk("ir_q",    ifc.ir_q,         e.ir);
      chk("sel_err", 32'(ifc.sel_err), 32'(e.err));
      chk("err_cnt", 32'(ifc.err_cnt), 32'(e.cnt));
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    stim_t s;
    int    guard;
    reg_clear_n = 1'b0;
    ifc.BusMuxOut = '0; ifc.IRin = 1'b0; ifc.Gra = 1'b0; ifc.Grb = 1'b0; ifc.Grc = 1'b0;
    ifc.Rin = 1'b0; ifc.Rout = 1'b0; ifc.BAout = 1'b0;
    @(posedge clk);
    #1;

    // Reset held with a pending load of all-ones
    for (int i = 0; i < 3; i++) do_cycle(mk(1'b0, 32'hFFFF_FFFF, 1, 0, 0, 0, 0, 0, 0));
    do_cycle(mk(1'b1, 32'h0, 0, 0, 0, 0, 0, 0, 0));

    // Load IR with Ra=5, Rb=3, Rc=3
    do_cycle(mk(1'b1, 32'h0A99_8000, 1, 0, 0, 0, 0, 0, 0));
    do_cycle(mk(1'b1, 32'h0, 0, 1, 0, 0, 1, 0, 0));
    do_cycle(mk(1'b1, 32'h0, 0, 0, 1, 0, 0, 1, 0));
    // Load and decode in the same cycle: old Rc is used
    do_cycle(mk(1'b1, 32'hF87F_FFFF, 1, 0, 0, 1, 0, 1, 0));
    // Rin and Rout together, no field select (R0)
    do_cycle(mk(1'b1, 32'h0, 0, 0, 0, 0, 1, 1, 0));
    // Rb=0 with BAout
    do_cycle(mk(1'b1, 32'h2807_8000, 1, 0, 0, 0, 0, 0, 0));
    do_cycle(mk(1'b1, 32'h0, 0, 0, 1, 0, 0, 0, 1));
    // C field extremes
    do_cycle(mk(1'b1, 32'h0004_0001, 1, 0, 0, 0, 0, 0, 0));
    do_cycle(mk(1'b1, 32'h0000_0005, 1, 0, 0, 0, 0, 0, 0));
    do_cycle(mk(1'b1, 32'h0, 0, 0, 0, 0, 0, 0, 0));

    // Sustained conflict long enough to saturate the counter
    for (int i = 0; i < 300; i++) do_cycle(mk(1'b1, 32'h0, 0, 1, 1, 0, 0, 1, 0));
    do_cycle(mk(1'b1, 32'h0, 0, 0, 0, 0, 0, 0, 0));
    // Reset clears the monitor
    do_cycle(mk(1'b0, 32'h1234_5678, 1, 0, 0, 0, 0, 0, 0));
    do_cycle(mk(1'b1, 32'h0, 0, 0, 0, 0, 0, 0, 0));

    // Randomised traffic
    for (int i = 0; i < 600; i++) begin
      s.rst_n = ($urandom_range(0, 59) != 0);
      s.bus   = $urandom;
      s.irin  = ($urandom_range(0, 3) == 0);
      s.gra   = 1'($urandom_range(0, 1));
      s.grb   = 1'($urandom_range(0, 1));
      s.grc   = 1'($urandom_range(0, 1));
      s.rin   = 1'($urandom_range(0, 1));
      s.rout  = 1'($urandom_range(0, 1));
      s.baout = ($urandom_range(0, 3) == 0);
      do_cycle(s);
    end

    guard = 0;
    while (exp_q.size() > 0 && guard < 10) begin
      @(posedge clk);
      guard++;
    end
    if (exp_q.size() > 0) begin
      n_checks++;
      $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
